// File: rtl/serial_adder_seq.sv
// serial_adder_seq
//   Bit-serial ripple adder. Accepts an operand pair over a valid/ready
//   handshake, adds one bit per enabled cycle (LSB first) through a
//   sum/carry cell with a registered carry, then presents the WIDTH-bit
//   sum and carry-out over a second valid/ready handshake.
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   ena        tile enable; low freezes all state
//   in_valid   operand pair offered
//   in_ready   block accepts operands (IDLE only)
//   a, b       operands, sampled on accept
//   out_valid  result available (DONE only)
//   out_ready  consumer takes result
//   sum        (a + b) mod 2^WIDTH
//   cout       carry out of bit WIDTH-1
//   busy       high in SHIFT or DONE
module serial_adder_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic             carry;
  logic [CW-1:0]    cnt;

  // Sum/carry cell: half-adder of the operand bits chained with the
  // registered carry.
  logic hs;
  logic s_bit;
  logic c_next;
  assign hs     = a_sh[0] ^ b_sh[0];
  assign s_bit  = hs ^ carry;
  assign c_next = (a_sh[0] & b_sh[0]) | (carry & hs);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else if (ena) begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh   <= a;
            b_sh   <= b;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          carry  <= c_next;
          // Sum bits enter at the MSB and drift down, so after WIDTH
          // shifts bit 0 sits at sum_sh[0].
          sum_sh <= {s_bit, sum_sh[WIDTH-1:1]};
          a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) state <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode straight from registers; no input-to-output path.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == SHIFT) || (state == DONE);
  assign sum       = sum_sh;
  assign cout      = carry;

endmodule

// File: tb/tb_serial_adder_seq.sv
module tb_serial_adder_seq;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, ena, in_valid, in_ready, out_valid, out_ready, cout, busy;
  logic [W-1:0] a, b, sum;

  int checks = 0;
  int failures = 0;

  serial_adder_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .ena(ena),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] s;
    logic         c;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Offer one pair, return edges from accept until out_valid is seen.
  task automatic accept_and_wait(input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input bit ena_gap, output int lat);
    int n;
    a = av; b = bv; in_valid = 1'b1;
    tick();                       // accept edge E0
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin
      ena = (ena_gap && n >= 2 && n <= 4) ? 1'b0 : 1'b1;
      tick();
      n++;
    end
    ena = 1'b1;
    lat = n;
  endtask

  vec_t vecs[4];
  int   lat;

  initial begin
    vecs[0] = '{8'h5A, 8'h3C, 8'h96, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 8'hFE, 1'b1};
    vecs[3] = '{8'h80, 8'h7F, 8'hFF, 1'b0};

    rst = 1'b1; ena = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    tick(); tick();
    rst = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);

    // Table-driven: out_ready held high, so transfer at first out_valid edge.
    for (int i = 0; i < 4; i++) begin
      accept_and_wait(vecs[i].a, vecs[i].b, 1'b0, lat);
      check($sformatf("v%0d_latency", i), lat, W);
      check($sformatf("v%0d_sum", i), sum, vecs[i].s);
      check($sformatf("v%0d_cout", i), cout, vecs[i].c);
      check($sformatf("v%0d_in_ready_low", i), in_ready, 0);
      tick();                     // transfer edge
      check($sformatf("v%0d_in_ready_back", i), in_ready, 1);
      check($sformatf("v%0d_out_valid_drop", i), out_valid, 0);
    end

    // Back-pressure with an ignored in_valid while waiting.
    out_ready = 1'b0;
    accept_and_wait(8'h5A, 8'h3C, 1'b0, lat);
    check("bp_latency", lat, W);
    a = 8'h11; b = 8'h11; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check("bp_out_valid", out_valid, 1);
      check("bp_sum", sum, 8'h96);
      check("bp_cout", cout, 0);
      check("bp_in_ready", in_ready, 0);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("bp_still_valid", out_valid, 1);
    tick();
    check("bp_xfer_valid", out_valid, 0);
    check("bp_xfer_ready", in_ready, 1);
    tick();
    check("bp_no_stale_start", busy, 0);

    // ena low for 3 cycles mid-SHIFT.
    accept_and_wait(8'h0F, 8'h01, 1'b1, lat);
    check("ena_latency", lat, W + 3);
    check("ena_sum", sum, 8'h10);
    check("ena_cout", cout, 0);
    tick();

    // Reset at bit 4 aborts the operation.
    a = 8'hAA; b = 8'h55; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) tick();   // bits 0..3 processed
    check("abort_busy_before", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_in_ready", in_ready, 1);
    check("abort_busy", busy, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_sum", sum, 0);
    check("abort_cout", cout, 0);
    for (int k = 0; k < W + 2; k++) begin
      check("abort_no_result", out_valid, 0);
      tick();
    end
    accept_and_wait(8'h01, 8'h01, 1'b0, lat);
    check("post_latency", lat, W);
    check("post_sum", sum, 8'h02);
    check("post_cout", cout, 0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
